// File: rtl/fetch_mem_arbiter.sv
// fetch_mem_arbiter
//   Shares one single-port instruction/data memory between instruction fetch
//   and load/store. One transaction at a time, req/ack handshake with variable
//   latency, round-robin when both sides ask, redirect squash, and a timeout
//   that aborts transactions the memory never acknowledges.
// Ports:
//   clk, rst                  clock, async active-low reset
//   if_req/if_addr/redirect   fetch request, PC, squash of in-flight fetch
//   if_valid/if_rdata/pc_en   fetched instruction, one-cycle valid + PC advance
//   d_req/d_we/d_addr/d_wdata load/store request
//   d_valid/d_rdata/stall     data completion, load data, pipeline hold
//   mem_req/we/addr/wdata     registered memory command, held until mem_ack
//   mem_ack/mem_rdata         memory completion and read data
//   err                       sticky timeout flag
module fetch_mem_arbiter #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              redirect,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  output logic              pc_en,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              err
);

  typedef enum logic [1:0] {IDLE = 2'd0, IF_BUSY = 2'd1, D_BUSY = 2'd2} state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_cmd_t;

  state_t            state_q, state_d;
  mem_cmd_t          cmd_q, cmd_d;
  logic              req_q, req_d;
  logic              squash_q, squash_d;
  logic              last_d_q, last_d_d;   // 1: last grant went to data
  logic [7:0]        cnt_q, cnt_d;
  logic              ifv_q, ifv_d, dv_q, dv_d, err_q, err_d;
  logic [DATA_W-1:0] ifr_q, ifr_d, dr_q, dr_d;

  logic want_if, want_d, pick_d, tmo;

  // A requester whose valid pulse is out this cycle still shows its old
  // request (PC/pipeline advance on this edge), so it must not be re-granted.
  assign want_if = if_req & ~ifv_q;
  assign want_d  = d_req & ~dv_q;
  assign pick_d  = want_d & (~want_if | ~last_d_q);
  // This busy cycle is the TIMEOUT-th without an ack.
  assign tmo     = (cnt_q == 8'(TIMEOUT - 1));

  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    req_d    = req_q;
    squash_d = squash_q;
    last_d_d = last_d_q;
    cnt_d    = cnt_q;
    ifv_d    = 1'b0;
    dv_d     = 1'b0;
    err_d    = err_q;
    ifr_d    = ifr_q;
    dr_d     = dr_q;
    case (state_q)
      IDLE: begin
        if (want_if | want_d) begin
          if (pick_d) begin
            cmd_d.we    = d_we;
            cmd_d.addr  = d_addr;
            cmd_d.wdata = d_wdata;
            state_d     = D_BUSY;
          end else begin
            cmd_d.we    = 1'b0;
            cmd_d.addr  = if_addr;
            cmd_d.wdata = '0;
            state_d     = IF_BUSY;
          end
          req_d    = 1'b1;
          cnt_d    = '0;
          squash_d = 1'b0;
          last_d_d = pick_d;
        end
      end
      IF_BUSY: begin
        if (redirect) squash_d = 1'b1;
        if (mem_ack) begin
          req_d    = 1'b0;
          squash_d = 1'b0;
          state_d  = IDLE;
          // same-cycle redirect also kills the returning word
          if (!squash_q && !redirect) begin
            ifv_d = 1'b1;
            ifr_d = mem_rdata;
          end
        end else if (tmo) begin
          req_d    = 1'b0;
          squash_d = 1'b0;
          err_d    = 1'b1;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      D_BUSY: begin
        if (mem_ack) begin
          req_d   = 1'b0;
          dv_d    = 1'b1;
          state_d = IDLE;
          if (!cmd_q.we) dr_d = mem_rdata;
        end else if (tmo) begin
          // complete with zero data so the core is released
          req_d   = 1'b0;
          dv_d    = 1'b1;
          dr_d    = '0;
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cmd_q    <= '0;
      req_q    <= 1'b0;
      squash_q <= 1'b0;
      last_d_q <= 1'b0;
      cnt_q    <= '0;
      ifv_q    <= 1'b0;
      dv_q     <= 1'b0;
      err_q    <= 1'b0;
      ifr_q    <= '0;
      dr_q     <= '0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      req_q    <= req_d;
      squash_q <= squash_d;
      last_d_q <= last_d_d;
      cnt_q    <= cnt_d;
      ifv_q    <= ifv_d;
      dv_q     <= dv_d;
      err_q    <= err_d;
      ifr_q    <= ifr_d;
      dr_q     <= dr_d;
    end
  end

  assign mem_req   = req_q;
  assign mem_we    = cmd_q.we;
  assign mem_addr  = cmd_q.addr;
  assign mem_wdata = cmd_q.wdata;
  assign if_valid  = ifv_q;
  assign pc_en     = ifv_q;
  assign if_rdata  = ifr_q;
  assign d_valid   = dv_q;
  assign d_rdata   = dr_q;
  assign err       = err_q;
  // gated by rst so every output reads 0 while reset is held
  assign stall     = rst & (want_d | (state_q == D_BUSY));

endmodule

// File: tb/tb_fetch_mem_arbiter.sv
// Bench for fetch_mem_arbiter: directed scenarios followed by random traffic,
// every cycle compared against a transaction-level reference model.
module tb_fetch_mem_arbiter;

  localparam int TMO = 15;

  logic        clk, rst;
  logic        if_req, redirect, d_req, d_we, mem_ack;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic        if_valid, pc_en, d_valid, stall, mem_req, mem_we, err;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;

  fetch_mem_arbiter #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .redirect(redirect),
    .if_valid(if_valid), .if_rdata(if_rdata), .pc_en(pc_en),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_valid(d_valid), .d_rdata(d_rdata), .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---- reference model: one outstanding transaction record ----
  localparam int NONE = 0, FETCH = 1, DATA = 2;
  int          m_own;      // who owns the memory
  int          m_wait;     // unacked cycles of current transaction
  logic        m_req, m_we, m_sq, m_lastd, m_ifv, m_dv, m_err;
  logic [31:0] m_addr, m_wdata, m_ifr, m_dr;

  task automatic model_reset();
    m_own = NONE; m_wait = 0;
    m_req = 0; m_we = 0; m_sq = 0; m_lastd = 0;
    m_ifv = 0; m_dv = 0; m_err = 0;
    m_addr = 0; m_wdata = 0; m_ifr = 0; m_dr = 0;
  endtask

  // Advance one clock edge given the inputs present before the edge.
  task automatic model_step();
    logic f, d, nifv, ndv;
    nifv = 0; ndv = 0;
    if (m_own == NONE) begin
      f = if_req && !m_ifv;   // requester with a pulse out is still retiring
      d = d_req && !m_dv;
      if (f || d) begin
        if (d && (!f || !m_lastd)) begin
          m_own = DATA; m_we = d_we; m_addr = d_addr; m_wdata = d_wdata; m_lastd = 1;
        end else begin
          m_own = FETCH; m_we = 0; m_addr = if_addr; m_lastd = 0;
        end
        m_req = 1; m_wait = 0; m_sq = 0;
      end
    end else begin
      if (m_own == FETCH && redirect) m_sq = 1;
      if (mem_ack) begin
        if (m_own == FETCH) begin
          if (!m_sq) begin nifv = 1; m_ifr = mem_rdata; end
        end else begin
          ndv = 1;
          if (!m_we) m_dr = mem_rdata;
        end
        m_req = 0; m_own = NONE; m_sq = 0;
      end else begin
        m_wait++;
        if (m_wait == TMO) begin
          if (m_own == DATA) begin ndv = 1; m_dr = 0; end
          m_req = 0; m_err = 1; m_own = NONE; m_sq = 0;
        end
      end
    end
    m_ifv = nifv;
    m_dv  = ndv;
  endtask

  task automatic check_outputs(input logic rv);
    logic exp_stall;
    exp_stall = rv && ((d_req && !m_dv) || m_own == DATA);
    chk("mem_req", 32'(mem_req), 32'(m_req));
    if (m_req || !rv) begin
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_we", 32'(mem_we), 32'(m_we));
      if (m_we || !rv) chk("mem_wdata", mem_wdata, m_wdata);
    end
    chk("if_valid", 32'(if_valid), 32'(m_ifv));
    chk("pc_en", 32'(pc_en), 32'(m_ifv));
    chk("if_rdata", if_rdata, m_ifr);
    chk("d_valid", 32'(d_valid), 32'(m_dv));
    chk("d_rdata", d_rdata, m_dr);
    chk("err", 32'(err), 32'(m_err));
    chk("stall", 32'(stall), 32'(exp_stall));
  endtask

  // Called just after a falling edge; returns just after the next one.
  task automatic step(input logic ir, input logic [31:0] ia, input logic rdr,
                      input logic dq, input logic dw, input logic [31:0] da,
                      input logic [31:0] dd, input logic ak, input logic [31:0] mr,
                      input logic rv);
    if_req = ir; if_addr = ia; redirect = rdr;
    d_req = dq; d_we = dw; d_addr = da; d_wdata = dd;
    mem_ack = ak; mem_rdata = mr; rst = rv;
    if (!rv) model_reset();
    #1;
    check_outputs(rv);
    @(posedge clk);
    if (rv) model_step();
    @(negedge clk);
  endtask

  task automatic idle(input logic ak, input logic rv);
    step(0, 0, 0, 0, 0, 0, 0, ak, 32'hBAD0_BAD0, rv);
  endtask

  initial begin
    int mcnt, lat;
    logic ak, rv;
    if_req = 0; if_addr = 0; redirect = 0; d_req = 0; d_we = 0;
    d_addr = 0; d_wdata = 0; mem_ack = 0; mem_rdata = 0; rst = 0;
    model_reset();
    @(negedge clk);
    idle(0, 0);
    idle(0, 0);
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_err", 32'(err), 0);

    // fetch at 0, immediate ack with 0x13
    step(1, 32'h0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("p1_addr", mem_addr, 32'h0);
    chk("p1_req", 32'(mem_req), 1);
    step(1, 32'h0, 0, 0, 0, 0, 0, 1, 32'h13, 1);
    chk("p1_rdata", if_rdata, 32'h13);
    chk("p1_pc_en", 32'(pc_en), 1);
    idle(0, 1);
    chk("p1_pulse_once", 32'(if_valid), 0);

    // both requesting: data wins after a fetch grant, then fetch
    step(1, 32'h4, 0, 1, 0, 32'h100, 0, 0, 0, 1);
    chk("p2_data_first", mem_addr, 32'h100);
    chk("p2_stall", 32'(stall), 1);
    step(1, 32'h4, 0, 1, 0, 32'h100, 0, 1, 32'hDEAD_BEEF, 1);
    chk("p2_d_rdata", d_rdata, 32'hDEAD_BEEF);
    chk("p2_d_valid", 32'(d_valid), 1);
    step(1, 32'h4, 0, 1, 0, 32'h100, 0, 0, 0, 1);
    chk("p2_fetch_next", mem_addr, 32'h4);
    step(1, 32'h4, 0, 0, 0, 0, 0, 1, 32'h0000_0093, 1);
    idle(0, 1);

    // fetch at 8, redirect during wait, ack on 3rd wait cycle is squashed
    step(1, 32'h8, 0, 0, 0, 0, 0, 0, 0, 1);
    step(1, 32'h8, 0, 0, 0, 0, 0, 0, 0, 1);
    step(1, 32'h8, 1, 0, 0, 0, 0, 0, 0, 1);
    step(1, 32'h40, 0, 0, 0, 0, 0, 1, 32'hFFFF_FFFF, 1);
    chk("p3_squash", 32'(if_valid), 0);
    step(1, 32'h40, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("p3_new_addr", mem_addr, 32'h40);
    step(1, 32'h40, 0, 0, 0, 0, 0, 1, 32'h0400_006F, 1);
    chk("p3_rdata", if_rdata, 32'h0400_006F);
    idle(0, 1);

    // store: command stable until ack, d_rdata untouched
    step(0, 0, 0, 1, 1, 32'h200, 32'h1234_5678, 0, 0, 1);
    step(0, 0, 0, 1, 1, 32'h200, 32'h1234_5678, 0, 0, 1);
    chk("p4_we", 32'(mem_we), 1);
    chk("p4_wdata", mem_wdata, 32'h1234_5678);
    step(0, 0, 0, 1, 1, 32'h200, 32'h1234_5678, 1, 32'h5555_5555, 1);
    chk("p4_d_valid", 32'(d_valid), 1);
    chk("p4_d_rdata", d_rdata, 32'hDEAD_BEEF);
    idle(0, 1);

    // fetch never acked -> abort after TMO busy cycles
    step(1, 32'hC, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < TMO - 1; i++) idle(0, 1);
    chk("p5_req_held", 32'(mem_req), 1);
    idle(0, 1);
    chk("p5_req_drop", 32'(mem_req), 0);
    chk("p5_err", 32'(err), 1);
    idle(0, 1);
    idle(0, 1);
    chk("p5_err_sticky", 32'(err), 1);

    // reset during a load, late ack ignored
    step(0, 0, 0, 1, 0, 32'h300, 0, 0, 0, 1);
    step(0, 0, 0, 1, 0, 32'h300, 0, 0, 0, 1);
    step(0, 0, 0, 1, 0, 32'h300, 0, 0, 0, 0);
    idle(1, 1);
    chk("p6_late_ack", 32'(d_valid), 0);
    chk("p6_req", 32'(mem_req), 0);

    // random traffic
    mcnt = 0; lat = 1;
    for (int c = 0; c < 4000; c++) begin
      if (mem_req) begin
        mcnt++;
        ak = (mcnt == lat);
      end else begin
        mcnt = 0;
        lat = ($urandom_range(0, 15) == 0) ? 40 : int'($urandom_range(1, 4));
        ak = ($urandom_range(0, 7) == 0);
      end
      rv = ($urandom_range(0, 299) != 0);
      step(1'($urandom_range(0, 1)), $urandom & 32'hFFFC, ($urandom_range(0, 5) == 0),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom & 32'hFFFC,
           $urandom, ak, $urandom, rv);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
